// File: rtl/piradip_spi_device_core.sv
// piradip_spi_device_core: oversampling SPI target, all four modes, multi-word frames, tx holding register
module piradip_spi_device_core #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL_VALUE = WIDTH'(8'hBB),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 csn,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  output logic                 underrun,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_mosi_s, r_csn_s;
  logic r_sclk_d, r_csn_d, r_cpol, r_cpha, r_need, r_miso, r_rx_valid, r_underrun, r_abort, r_hold_v;
  logic [WIDTH-1:0] r_shreg, r_hold, r_rx_data;
  logic [WIDTH-2:0] r_rxsh;
  logic [BW-1:0] r_bit_cnt;
  logic [CNT_WIDTH-1:0] r_wc;
  logic w_sclk, w_mosi, w_rise, w_fall, w_lead, w_trail, w_csn_fall, w_csn_rise;
  logic w_start, w_stop, w_run, w_samp, w_shift, w_load, w_last;
  logic [WIDTH-1:0] w_load_word, w_rx_next;
  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_lead      = r_cpol ? w_fall : w_rise;
  assign w_trail     = r_cpol ? w_rise : w_fall;
  assign w_csn_fall  = ~r_csn_s[SYNC_STAGES-1] & r_csn_d;
  assign w_csn_rise  = r_csn_s[SYNC_STAGES-1] & ~r_csn_d;
  assign w_load_word = r_hold_v ? r_hold : FILL_VALUE;
  assign w_rx_next   = {r_rxsh, w_mosi};
  assign w_last      = r_bit_cnt == BW'(WIDTH - 1);
  assign miso        = r_miso;
  assign miso_oe     = r_state == ACTIVE;
  assign busy        = r_state == ACTIVE;
  assign tx_ready    = ~r_hold_v;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign underrun    = r_underrun;
  assign frame_abort = r_abort;
  assign word_count  = r_wc;
  // synchronizers; csn resets to low so a frame only starts after csn is seen high again
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_csn_s  <= '0;
      r_sclk_d <= 1'b0;
      r_csn_d  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_csn_s  <= {r_csn_s[SYNC_STAGES-2:0], csn};
      r_sclk_d <= w_sclk;
      r_csn_d  <= r_csn_s[SYNC_STAGES-1];
    end
  end
  // frame state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // frame entry on csn fall, exit on csn rise
  always_comb begin
    w_next = (r_state == IDLE) ? (w_csn_fall ? ACTIVE : IDLE) : (w_csn_rise ? IDLE : ACTIVE);
  end
  // per-cycle strobes; a csn rise masks any coincident sclk edge
  always_comb begin
    w_start = (r_state == IDLE) & w_csn_fall;
    w_stop  = (r_state == ACTIVE) & w_csn_rise;
    w_run   = (r_state == ACTIVE) & ~w_csn_rise;
    w_samp  = w_run & (r_cpha ? w_trail : w_lead);
    w_shift = w_run & (r_cpha ? w_lead : w_trail);
    w_load  = w_start | (w_shift & r_need);
  end
  // tx holding register: accept only when empty, emptied by every load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else begin
      if (tx_valid & ~r_hold_v) r_hold <= tx_data;
      r_hold_v <= (tx_valid & ~r_hold_v) | (r_hold_v & ~w_load);
    end
  end
  // shift, sample and word bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_need     <= 1'b0;
      r_miso     <= 1'b0;
      r_shreg    <= '0;
      r_rxsh     <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_bit_cnt  <= '0;
      r_wc       <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      if (w_start) begin
        r_cpol     <= cfg_cpol;
        r_cpha     <= cfg_cpha;
        r_need     <= 1'b0;
        r_wc       <= '0;
        r_bit_cnt  <= '0;
        r_shreg    <= cfg_cpha ? w_load_word : {w_load_word[WIDTH-2:0], 1'b0};
        r_miso     <= ~cfg_cpha & w_load_word[WIDTH-1];
        r_underrun <= ~r_hold_v;
      end
      if (w_stop) begin
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
        r_abort   <= r_bit_cnt != '0;
      end
      if (w_samp) begin
        r_rxsh     <= w_rx_next[WIDTH-2:0];
        r_bit_cnt  <= w_last ? '0 : r_bit_cnt + BW'(1);
        r_need     <= r_need | w_last;
        r_rx_valid <= w_last;
        if (w_last) r_rx_data <= w_rx_next;
        if (w_last) r_wc <= (&r_wc) ? r_wc : r_wc + CNT_WIDTH'(1);
      end
      if (w_shift) begin
        r_need     <= 1'b0;
        r_miso     <= r_need ? w_load_word[WIDTH-1] : r_shreg[WIDTH-1];
        r_shreg    <= r_need ? {w_load_word[WIDTH-2:0], 1'b0} : {r_shreg[WIDTH-2:0], 1'b0};
        r_underrun <= r_need & ~r_hold_v;
      end
    end
  end
endmodule

// File: tb/tb_piradip_spi_device_core.sv
// tb_piradip_spi_device_core: randomized SPI controller against a word-level reference model
module tb_piradip_spi_device_core;
  localparam int W = 8, SS = 2, H = 8;
  localparam logic [7:0] FILL = 8'hBB;
  logic clk = 0, rst = 1, cfg_cpol = 0, cfg_cpha = 0, sclk = 0, mosi = 0, csn = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic miso, miso_oe, tx_ready, rx_valid, underrun, frame_abort, busy;
  logic [7:0] rx_data;
  logic [15:0] word_count;
  int checks = 0, errors = 0, n_rxv = 0, n_under = 0, n_abort = 0;
  logic [7:0] rxq[$], src[$], mq[$];
  logic push_en = 1;
  logic [7:0] mw[4], got[4];
  logic mid_busy, mid_oe;

  piradip_spi_device_core #(.WIDTH(W), .SYNC_STAGES(SS), .FILL_VALUE(FILL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .sclk(sclk), .mosi(mosi), .csn(csn),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .frame_abort(frame_abort),
    .busy(busy), .word_count(word_count));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clk);
    if (rx_valid) begin n_rxv++; rxq.push_back(rx_data); end
    if (underrun) n_under++;
    if (frame_abort) n_abort++;
  end

  initial forever begin
    @(negedge clk);
    if (push_en && src.size() > 0 && tx_ready && !rst) begin
      tx_valid = 1; tx_data = src[0];
      @(posedge clk); #1;
      void'(src.pop_front());
      tx_valid = 0;
    end
  end

  task automatic wait_c(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic supply(input logic [7:0] w);
    src.push_back(w); mq.push_back(w);
  endtask

  task automatic spi_frame(input logic cpol, input logic cpha, input int nbits);
    cfg_cpol = cpol; cfg_cpha = cpha; sclk = cpol;
    for (int k = 0; k < 4; k++) got[k] = 0;
    wait_c(H); csn = 0; wait_c(H);
    for (int i = 0; i < nbits; i++) begin
      automatic int k = i / 8;
      automatic int b = 7 - i % 8;
      if (!cpha) begin
        mosi = mw[k][b]; wait_c(H); sclk = ~cpol; got[k][b] = miso; wait_c(H); sclk = cpol;
      end else begin
        sclk = ~cpol; wait_c(H / 2); mosi = mw[k][b]; wait_c(H / 2); sclk = cpol; got[k][b] = miso; wait_c(H);
      end
      if (i == 1) begin mid_busy = busy; mid_oe = miso_oe; end
    end
    wait_c(H); csn = 1;
  endtask

  task automatic test_frame(input logic cpol, input logic cpha, input int nbits, input logic [31:0] words);
    int n, p, t, l, eu;
    logic [7:0] ew[5];
    logic [7:0] m;
    for (int k = 0; k < 4; k++) mw[k] = words[31-8*k -: 8];
    rxq.delete(); n_rxv = 0; n_under = 0; n_abort = 0;
    spi_frame(cpol, cpha, nbits);
    wait_c(SS + 2);
    n = nbits / 8; p = nbits % 8; t = n + (p != 0 ? 1 : 0);
    l = cpha ? (t > 0 ? t : 1) : n + 1;
    eu = 0;
    for (int k = 0; k < l; k++) begin
      if (mq.size() > 0) ew[k] = mq.pop_front();
      else begin ew[k] = FILL; eu++; end
    end
    checks++;
    if ({mid_busy, mid_oe} !== 2'b11) begin errors++; $display("FAIL mid_busy_oe mode=%0d%0d bits=%0d got=%b want=11", cpol, cpha, nbits, {mid_busy, mid_oe}); end
    checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin errors++; $display("FAIL end_idle mode=%0d%0d bits=%0d got=%b want=000", cpol, cpha, nbits, {busy, miso_oe, miso}); end
    checks++;
    if (n_abort != (p != 0 ? 1 : 0)) begin errors++; $display("FAIL abort_count mode=%0d%0d bits=%0d got=%0d want=%0d", cpol, cpha, nbits, n_abort, p != 0); end
    checks++;
    if (n_rxv != n) begin errors++; $display("FAIL rx_count mode=%0d%0d bits=%0d got=%0d want=%0d", cpol, cpha, nbits, n_rxv, n); end
    checks++;
    if (n_under != eu) begin errors++; $display("FAIL underrun_count mode=%0d%0d bits=%0d got=%0d want=%0d", cpol, cpha, nbits, n_under, eu); end
    checks++;
    if (word_count !== 16'(n)) begin errors++; $display("FAIL word_count mode=%0d%0d bits=%0d got=%0d want=%0d", cpol, cpha, nbits, word_count, n); end
    for (int k = 0; k < n && k < rxq.size(); k++) begin
      checks++;
      if (rxq[k] !== mw[k]) begin errors++; $display("FAIL rx_data[%0d] mode=%0d%0d got=%h want=%h", k, cpol, cpha, rxq[k], mw[k]); end
    end
    for (int k = 0; k < t; k++) begin
      m = (k < n) ? 8'hFF : ~(8'hFF >> p);
      checks++;
      if (got[k] !== (ew[k] & m)) begin errors++; $display("FAIL miso_word[%0d] mode=%0d%0d got=%h want=%h", k, cpol, cpha, got[k], ew[k] & m); end
    end
    wait_c(2 * H);
  endtask

  task automatic test_reset;
    rst = 1; wait_c(3);
    checks++;
    if ({miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready} !== {30'b0, 1'b1}) begin
      errors++; $display("FAIL reset_during got=%h want=%h", {miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready}, {30'b0, 1'b1});
    end
    rst = 0; wait_c(2);
    checks++;
    if ({miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready} !== {30'b0, 1'b1}) begin
      errors++; $display("FAIL reset_after got=%h want=%h", {miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready}, {30'b0, 1'b1});
    end
  endtask

  task automatic test_modes;
    for (int md = 0; md < 4; md++) begin
      supply(8'hA5);
      test_frame(md[1], md[0], 8, {8'h3C, 24'($urandom)});
    end
  endtask

  task automatic test_multiword;
    supply(8'h11); supply(8'h22);
    test_frame(1, 1, 24, $urandom);
  endtask

  task automatic test_abort;
    supply(8'($urandom));
    test_frame(0, 0, 5, $urandom);
  endtask

  task automatic test_reset_mid;
    supply(8'($urandom)); wait_c(4);
    cfg_cpol = 0; cfg_cpha = 0; sclk = 0; csn = 0; wait_c(H);
    repeat (3) begin mosi = 1'($urandom); wait_c(H); sclk = 1; wait_c(H); sclk = 0; end
    rst = 1; wait_c(2);
    checks++;
    if ({miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready} !== {30'b0, 1'b1}) begin
      errors++; $display("FAIL reset_mid got=%h want=%h", {miso, miso_oe, rx_data, rx_valid, underrun, frame_abort, busy, word_count, tx_ready}, {30'b0, 1'b1});
    end
    rst = 0; mq.delete(); n_rxv = 0; n_under = 0;
    repeat (9) begin mosi = 1'($urandom); wait_c(H); sclk = 1; wait_c(H); sclk = 0; end
    checks++;
    if (busy !== 1'b0 || n_rxv != 0 || n_under != 0) begin
      errors++; $display("FAIL csn_low_after_reset busy=%b rx=%0d under=%0d want busy=0 rx=0 under=0", busy, n_rxv, n_under);
    end
    csn = 1; wait_c(2 * H);
    test_frame(1'($urandom), 1'($urandom), 8, $urandom);
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    push_en = 0;
    @(negedge clk); tx_valid = 1; tx_data = a;
    wait_c(1); tx_data = b;
    wait_c(5);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL hold_full_ready got=%b want=0", tx_ready); end
    mq.push_back(a); mq.push_back(b);
    fork
      test_frame(1'($urandom), 1, 8, $urandom);
      begin
        automatic int i = 0;
        while (busy !== 1'b1 && i < 400) begin @(negedge clk); i++; end
        checks++;
        if (busy !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_consume busy=%b tx_ready=%b want 1 1", busy, tx_ready); end
        wait_c(1);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL reaccept got=%b want=0", tx_ready); end
        tx_valid = 0;
      end
    join
    test_frame(1'($urandom), 1, 8, $urandom);
    push_en = 1;
  endtask

  task automatic test_random;
    repeat (6) begin
      repeat ($urandom_range(0, 3)) supply(8'($urandom));
      test_frame(1'($urandom), 1'($urandom), $urandom_range(2, 32), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_multiword;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piradip_spi_device_core.md
Name: piradip_spi_device_core

Overview:
Synthesizable SPI target (peripheral) that runs entirely in the system clock domain. It oversamples sclk, mosi and csn, and supports all four SPI modes, selected at runtime per transaction. Words are of parametrised width, multiple words per chip-select frame are allowed, and a transmit holding register uses a valid/ready handshake. It sits between an external SPI controller pin interface and on-chip register or stream logic, replacing behavioural device models wherever hardware is needed.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
SYNC_STAGES, 2, synchronizer flops on sclk/mosi/csn (>=2)
FILL_VALUE, 8'hBB (WIDTH bits), word shifted out when no tx word is held
CNT_WIDTH, 16, width of per-frame word counter

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
cfg_cpol  in  1  clock polarity; sampled on csn assertion
cfg_cpha  in  1  clock phase; sampled on csn assertion
sclk  in  1  SPI clock, asynchronous
mosi  in  1  SPI data in, asynchronous
csn  in  1  SPI chip select, active low, asynchronous
miso  out  1  SPI data out (registered)
miso_oe  out  1  tristate enable for miso (1 = drive)
tx_data  in  WIDTH  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty; transfer on tx_valid & tx_ready
rx_data  out  WIDTH  last received word, MSB first on wire
rx_valid  out  1  one-cycle pulse, rx_data updated
underrun  out  1  one-cycle pulse, FILL_VALUE loaded instead of a held word
frame_abort  out  1  one-cycle pulse, csn deasserted with a partial word
busy  out  1  frame in progress (synced csn low)
word_count  out  CNT_WIDTH  complete words received in the current/last frame

Behaviour:
- Reset (rst=1 at a clk edge): miso=0, miso_oe=0, rx_data=0, rx_valid=0, underrun=0, frame_abort=0, busy=0, word_count=0, hold empty (tx_ready=1 from the first cycle after reset), shift/bit counters=0, FSM=IDLE. Reset mid-frame discards everything. After reset, the FSM waits for csn high before honouring a new frame.
- Sync: sclk/mosi/csn each pass through SYNC_STAGES flops. Edges are detected on the last stage against one further delay flop. Required: sclk high and low times each >= SYNC_STAGES+3 clk periods.
- Lead edge = sclk leaving CPOL level. Trail edge = sclk returning to CPOL level.
- FSM IDLE -> ACTIVE on synced csn fall: latch cpol/cpha, busy=1, word_count=0, bit_cnt=0, miso_oe=1 on the same cycle. Load shift register from the hold (hold emptied) or, if empty, from FILL_VALUE with an underrun pulse. For CPHA=0, miso=shreg MSB on the next cycle.
- ACTIVE, CPHA=0: sample mosi on lead; shift out next bit on trail.
- ACTIVE, CPHA=1: shift out on lead (the first lead presents MSB); sample on trail.
- Word done when bit_cnt reaches WIDTH samples. On the cycle after the last sample: rx_valid=1, rx_data=assembled word, word_count+1 (saturating at all-ones), bit_cnt=0.
- Next word load: CPHA=0 on the trail edge after the last sample; CPHA=1 on the next lead edge. Source is the hold or FILL_VALUE with underrun, as above.
- Hold accept and consume in the same cycle is not possible (accept needs the hold empty). If the hold is empty at a load, FILL_VALUE is used even if tx_valid arrives that cycle; the accepted word goes to the hold for the following word.
- ACTIVE -> IDLE on synced csn rise: busy=0, miso_oe=0, miso=0. If bit_cnt != 0, pulse frame_abort and drop the partial word (no rx_valid). The hold content is retained. word_count holds its value until the next frame.
- sclk edges while IDLE are ignored. A csn rise and sclk edge in the same cycle: the csn rise wins and the edge is ignored.
- No rx backpressure: the consumer must take rx_data on rx_valid.

Test Plan:
- Mode 0, WIDTH=8, hold=0xA5, controller sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_valid once with rx_data=0x3C; word_count=1; no underrun.
- Modes 1/2/3 each: same transfer -> identical rx_data=0x3C, and miso 0xA5 sampled correctly by a controller using the same mode.
- Mode 3, 3-word frame, tx 0x11,0x22 supplied, third missing -> miso 0x11,0x22,0xBB; underrun pulses once on the third load; rx_valid x3; word_count=3.
- csn raised after 5 bits of mode 0 -> frame_abort pulse, no rx_valid, busy=0, miso_oe=0 within SYNC_STAGES+2 cycles.
- rst asserted mid-word, then a fresh frame -> all outputs at reset values, and the next frame starts from bit 0 with FILL_VALUE and an underrun pulse.
- Back-to-back tx_valid while tx_ready=0 -> no accept; hold value unchanged; tx_ready rises the cycle after the word is consumed.
